// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter slice: request record,
// register index width and the busy-scoreboard vector type.
package wb_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_NREG   = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] num;
    logic [WB_XLEN-1:0]   data;
  } wb_req_t;

  typedef logic [WB_NREG-1:0] busy_vec_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of write-back requests for long-latency results. Pointers
// carry one extra wrap bit so full and empty fall out of a pointer compare.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_b,
  input  logic    i_push,
  input  wb_req_t i_push_req,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output wb_req_t o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  wb_req_t     r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_req;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline and long-latency results onto the single regfile write port
// and tracks per-register busy state. Define WB_BYPASS_EN to forward same-cycle writes to reads.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int NREG       = WB_NREG,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 pipe_we,
  input  logic [REG_IDX_W-1:0] pipe_rd_num,
  input  logic [XLEN-1:0]      pipe_rd_data,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [REG_IDX_W-1:0] lu_rd_num,
  input  logic [XLEN-1:0]      lu_rd_data,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd_num,
  input  logic [REG_IDX_W-1:0] chk_rs_num,
  input  logic [REG_IDX_W-1:0] chk_rt_num,
  output logic                 chk_rs_busy,
  output logic                 chk_rt_busy,
  output logic                 rd_we,
  output logic [REG_IDX_W-1:0] rd_num,
  output logic [XLEN-1:0]      rd_data,
  input  logic [REG_IDX_W-1:0] rs_num_in,
  input  logic [REG_IDX_W-1:0] rt_num_in,
  input  logic [XLEN-1:0]      rs_data_in,
  input  logic [XLEN-1:0]      rt_data_in,
  output logic [XLEN-1:0]      rs_data_out,
  output logic [XLEN-1:0]      rt_data_out,
  output logic                 drained
);

  logic            w_pipe_wr;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  wb_req_t         w_push_req;
  wb_req_t         w_head;
  busy_vec_t       w_busy_set;
  busy_vec_t       w_busy_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic [NREG-1:0] r_busy;

  // Writes to r0 are architecturally void, so they neither win the port nor enqueue.
  assign w_pipe_wr  = pipe_we && (pipe_rd_num != '0);
  assign w_pop      = rst_b && !w_pipe_wr && !w_fifo_empty;
  assign lu_ready   = rst_b && !w_fifo_full;
  assign w_push     = lu_valid && lu_ready && (lu_rd_num != '0);
  assign w_push_req = '{num: lu_rd_num, data: lu_rd_data};

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_push     (w_push),
    .i_push_req (w_push_req),
    .i_pop      (w_pop),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_head     (w_head)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can infer a latch.
  always_comb begin
    rd_we   = 1'b0;
    rd_num  = '0;
    rd_data = '0;
    if (w_pipe_wr && rst_b) begin
      rd_we   = 1'b1;
      rd_num  = pipe_rd_num;
      rd_data = pipe_rd_data;
    end else if (w_pop) begin
      rd_we   = 1'b1;
      rd_num  = w_head.num;
      rd_data = w_head.data;
    end
  end

  // Clear is applied before set so an issue to a retiring register keeps it busy.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (iss_valid && (iss_rd_num != '0)) w_busy_set[iss_rd_num] = 1'b1;
    if (w_pop) w_busy_clr[w_head.num] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: state registers update only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign chk_rs_busy = r_busy[chk_rs_num];
  assign chk_rt_busy = r_busy[chk_rt_num];
  assign drained     = w_fifo_empty && (r_busy == '0);

`ifdef WB_BYPASS_EN
  assign rs_data_out = (rd_we && (rd_num == rs_num_in) && (rs_num_in != '0)) ? rd_data : rs_data_in;
  assign rt_data_out = (rd_we && (rd_num == rt_num_in) && (rt_num_in != '0)) ? rd_data : rt_data_in;
`else
  logic w_unused;
  assign w_unused    = ^{rs_num_in, rt_num_in};
  assign rs_data_out = rs_data_in;
  assign rt_data_out = rt_data_in;
`endif

endmodule
